// File: rtl/mem_access_sequencer_pkg.sv
// Shared types for the RAM access sequencer: FSM state encodings and requester grant codes.
package mem_access_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_READ  = 3'd2,
      ST_WRITE = 3'd3,
      ST_ACK   = 3'd4
   } state_t;

   localparam logic GRANT_FETCH = 1'b0;
   localparam logic GRANT_DATA  = 1'b1;

   // Round-robin hand-off: after a win, priority moves to the other requester.
   function automatic logic other_side(input logic winner);
      return ~winner;
   endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Requester handshakes plus shared-bus/MAR/RAM strobes around the sequencer.
interface mem_access_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              FetchReq;
   logic [ADDR_W-1:0] FetchAddr;
   logic              FetchAck;
   logic              DataReq;
   logic              DataWe;
   logic [ADDR_W-1:0] DataAddr;
   logic [DATA_W-1:0] DataWData;
   logic              DataAck;
   logic [DATA_W-1:0] RdData;
   logic [DATA_W-1:0] BusIn;
   logic [DATA_W-1:0] BusOut;
   logic              BusDrive;
   logic              MarIn;
   logic              RamOut;
   logic              RamIn;
   logic              Busy;

   modport master (
      output FetchReq, FetchAddr, DataReq, DataWe, DataAddr, DataWData, BusIn,
      input  FetchAck, DataAck, RdData, BusOut, BusDrive, MarIn, RamOut, RamIn, Busy
   );

   modport slave (
      input  FetchReq, FetchAddr, DataReq, DataWe, DataAddr, DataWData, BusIn,
      output FetchAck, DataAck, RdData, BusOut, BusDrive, MarIn, RamOut, RamIn, Busy
   );
endinterface

// File: rtl/mem_access_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer picks the winner only when both sides request.
module rr_arbiter2
   import mem_access_sequencer_pkg::*;
(
   input  logic       Clk,
   input  logic       Rst,
   input  logic [1:0] req,         // [GRANT_FETCH], [GRANT_DATA]
   input  logic       adv,
   input  logic       adv_winner,
   output logic       gnt,
   output logic       any
);
   logic ptr;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)      ptr <= GRANT_FETCH;
      else if (adv) ptr <= other_side(adv_winner);
   end

   assign any = |req;
   assign gnt = (req[GRANT_FETCH] && req[GRANT_DATA]) ? ptr : req[GRANT_DATA];
endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences MAR load then RAM read/write on the shared bus for fetch and data requesters.
module mem_access_sequencer
   import mem_access_sequencer_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input logic                   Clk,
   input logic                   Rst,
   mem_access_sequencer_if.slave sb
);
   localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } xact_t;

   state_t            state, state_nx;
   xact_t             cur;
   logic              cur_gnt;
   logic [CNT_W-1:0]  wait_cnt;
   logic [DATA_W-1:0] rd_data;
   logic              arb_gnt, arb_any, rd_last;

   rr_arbiter2 u_arb (
      .Clk        (Clk),
      .Rst        (Rst),
      .req        ({sb.DataReq, sb.FetchReq}),
      .adv        (state == ST_ACK),
      .adv_winner (cur_gnt),
      .gnt        (arb_gnt),
      .any        (arb_any)
   );

   assign rd_last = (wait_cnt == CNT_LAST);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (arb_any) state_nx = ST_ADDR;
         ST_ADDR:  state_nx = cur.we ? ST_WRITE : ST_READ;
         ST_WRITE: state_nx = ST_ACK;
         ST_READ:  if (rd_last) state_nx = ST_ACK;
         ST_ACK:   state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Request fields are captured once at grant so requesters may drop or change them mid-flight.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cur      <= '0;
         cur_gnt  <= GRANT_FETCH;
         wait_cnt <= '0;
         rd_data  <= '0;
      end else begin
         if (state == ST_IDLE && arb_any) begin
            cur_gnt <= arb_gnt;
            if (arb_gnt == GRANT_DATA)
               cur <= '{we: sb.DataWe, addr: sb.DataAddr, wdata: sb.DataWData};
            else
               cur <= '{we: 1'b0, addr: sb.FetchAddr, wdata: '0};
         end
         wait_cnt <= (state == ST_READ) ? wait_cnt + CNT_W'(1) : '0;
         if (state == ST_READ && rd_last) rd_data <= sb.BusIn;
      end
   end

   always_comb begin
      sb.BusDrive = 1'b0;
      sb.BusOut   = '0;
      sb.MarIn    = 1'b0;
      sb.RamIn    = 1'b0;
      sb.RamOut   = 1'b0;
      sb.FetchAck = 1'b0;
      sb.DataAck  = 1'b0;
      case (state)
         ST_ADDR: begin
            sb.BusDrive = 1'b1;
            sb.BusOut   = DATA_W'(cur.addr);
            sb.MarIn    = 1'b1;
         end
         ST_WRITE: begin
            sb.BusDrive = 1'b1;
            sb.BusOut   = cur.wdata;
            sb.RamIn    = 1'b1;
         end
         ST_READ: sb.RamOut = 1'b1;
         ST_ACK: begin
            sb.FetchAck = (cur_gnt == GRANT_FETCH);
            sb.DataAck  = (cur_gnt == GRANT_DATA);
         end
         default: ;
      endcase
   end

   assign sb.RdData = rd_data;
   assign sb.Busy   = (state != ST_IDLE);
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed vector table plus hand sequences (reset abort, contention, WAIT_CYCLES=3, random stress).
module tb_mem_access_sequencer;
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   mem_access_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bif ();
   mem_access_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bif3 ();

   mem_access_sequencer #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(1)) dut (
      .Clk(Clk), .Rst(Rst), .sb(bif));
   mem_access_sequencer #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (
      .Clk(Clk), .Rst(Rst), .sb(bif3));

   // MAR + RAM environment for the WAIT_CYCLES=1 instance
   logic [15:0] mem [256];
   logic [7:0]  mar = 8'h00;
   always @(posedge Clk) begin
      if (bif.MarIn) mar <= bif.BusOut[7:0];
      if (bif.RamIn) mem[mar] <= bif.BusOut;
   end
   assign bif.BusIn = bif.RamOut ? mem[mar] : (bif.BusDrive ? bif.BusOut : 16'h0000);

   logic [15:0] bus3_val = 16'h0000;
   assign bif3.BusIn = bus3_val;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (!Rst) begin
         if (bif.BusDrive && bif.RamOut) begin
            n_bad++; $display("FAIL inv_bus_conflict: BusDrive=1 RamOut=1, expected not both");
         end
         if (bif.FetchAck && bif.DataAck) begin
            n_bad++; $display("FAIL inv_two_acks: FetchAck=1 DataAck=1, expected at most one");
         end
         if (bif.MarIn && !(bif.BusDrive && !bif.RamIn && !bif.RamOut && bif.BusOut[15:8] == 8'h00)) begin
            n_bad++; $display("FAIL inv_marin: MarIn outside address phase, BusOut=%0h", bif.BusOut);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   typedef struct {
      bit          is_data;
      bit          we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      bit          preload;
      logic [15:0] pre;
      bit          drop1;
      int          exp_ack;
      logic [15:0] exp_rd;
      logic [15:0] exp_mem;
   } vec_t;

   vec_t vt[9];

   task automatic run_xact(input vec_t v, output int ack_c, output int mar_c,
                           output logic [15:0] mar_bus, output int ramin_c,
                           output logic [15:0] ramin_bus);
      ack_c = -1; mar_c = -1; ramin_c = -1; mar_bus = 'x; ramin_bus = 'x;
      if (v.is_data) begin
         bif.DataReq = 1'b1; bif.DataWe = v.we; bif.DataAddr = v.addr; bif.DataWData = v.wdata;
      end else begin
         bif.FetchReq = 1'b1; bif.FetchAddr = v.addr;
      end
      for (int c = 1; c <= 20 && ack_c < 0; c++) begin
         @(negedge Clk);
         if (bif.MarIn && mar_c < 0) begin mar_c = c; mar_bus = bif.BusOut; end
         if (bif.RamIn && ramin_c < 0) begin ramin_c = c; ramin_bus = bif.BusOut; end
         if (v.is_data ? bif.DataAck : bif.FetchAck) begin
            ack_c = c; bif.DataReq = 1'b0; bif.FetchReq = 1'b0;
         end
         if (v.drop1 && c == 1) begin
            bif.DataReq = 1'b0; bif.FetchReq = 1'b0;
            bif.DataAddr = ~v.addr; bif.FetchAddr = ~v.addr; bif.DataWData = ~v.wdata;
         end
      end
      @(negedge Clk);
   endtask

   initial begin
      int ack_c, mar_c, ramin_c;
      logic [15:0] mar_bus, ramin_bus;
      logic [3:0]  order;
      int          n_ack, last_ack, ack3, fa_cnt;
      logic [8:0]  ro_mask;
      logic        stray;
      logic [7:0]  fa, da;
      logic [15:0] dw;
      logic        dwe;

      //        data we addr   wdata    pre pre_val  drop ack rd       mem
      vt[0] = '{0, 0, 8'h12, 16'h0000, 1, 16'hBEEF, 0, 3, 16'hBEEF, 16'hBEEF};
      vt[1] = '{1, 1, 8'hFF, 16'h1234, 0, 16'h0000, 0, 3, 16'hBEEF, 16'h1234};
      vt[2] = '{1, 0, 8'hFF, 16'h0000, 0, 16'h0000, 0, 3, 16'h1234, 16'h1234};
      vt[3] = '{0, 0, 8'h00, 16'h0000, 1, 16'hA5A5, 0, 3, 16'hA5A5, 16'hA5A5};
      vt[4] = '{1, 1, 8'h00, 16'hFFFF, 0, 16'h0000, 0, 3, 16'hA5A5, 16'hFFFF};
      vt[5] = '{0, 0, 8'h00, 16'h0000, 0, 16'h0000, 0, 3, 16'hFFFF, 16'hFFFF};
      vt[6] = '{1, 0, 8'h80, 16'h0000, 1, 16'h0001, 0, 3, 16'h0001, 16'h0001};
      vt[7] = '{1, 1, 8'h7F, 16'h0000, 1, 16'hDEAD, 1, 3, 16'h0001, 16'h0000};
      vt[8] = '{0, 0, 8'hFF, 16'h0000, 0, 16'h0000, 1, 3, 16'h1234, 16'h1234};

      for (int i = 0; i < 256; i++) mem[i] = 16'(i);
      bif.FetchReq = 0; bif.FetchAddr = 0; bif.DataReq = 0; bif.DataWe = 0;
      bif.DataAddr = 0; bif.DataWData = 0;
      bif3.FetchReq = 0; bif3.FetchAddr = 0; bif3.DataReq = 0; bif3.DataWe = 0;
      bif3.DataAddr = 0; bif3.DataWData = 0;

      // reset state
      #1;
      check("rst_strobes", {bif.Busy, bif.MarIn, bif.RamIn, bif.RamOut, bif.BusDrive,
                            bif.FetchAck, bif.DataAck}, 0);
      check("rst_rddata", bif.RdData, 16'h0000);
      check("rst_busout", bif.BusOut, 16'h0000);
      check("rst_busy3", bif3.Busy, 0);
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);

      // directed vector table
      for (int i = 0; i < 9; i++) begin
         if (vt[i].preload) mem[vt[i].addr] = vt[i].pre;
         run_xact(vt[i], ack_c, mar_c, mar_bus, ramin_c, ramin_bus);
         check($sformatf("v%0d_ack_cycle", i), ack_c, vt[i].exp_ack);
         check($sformatf("v%0d_marin_cycle", i), mar_c, 1);
         check($sformatf("v%0d_mar_busout", i), mar_bus, {8'h00, vt[i].addr});
         if (vt[i].we) begin
            check($sformatf("v%0d_ramin_cycle", i), ramin_c, 2);
            check($sformatf("v%0d_ramin_busout", i), ramin_bus, vt[i].wdata);
         end else begin
            check($sformatf("v%0d_no_ramin", i), ramin_c, -1);
         end
         check($sformatf("v%0d_rddata", i), bif.RdData, vt[i].exp_rd);
         check($sformatf("v%0d_mem", i), mem[vt[i].addr], vt[i].exp_mem);
      end

      // reset in the middle of a read: abort with no ack
      bif.FetchReq = 1'b1; bif.FetchAddr = 8'h12;
      repeat (2) @(negedge Clk);
      check("midrd_ramout_pre", bif.RamOut, 1);
      Rst = 1'b1;
      #1;
      check("midrd_strobes", {bif.MarIn, bif.RamIn, bif.RamOut, bif.BusDrive,
                              bif.FetchAck, bif.DataAck}, 0);
      check("midrd_busy", bif.Busy, 0);
      check("midrd_rddata", bif.RdData, 16'h0000);
      bif.FetchReq = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;
      stray = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         stray |= bif.Busy | bif.FetchAck | bif.DataAck;
      end
      check("midrd_idle_after", stray, 0);

      // contention with back-to-back requests held through four transactions
      bif.FetchReq = 1'b1; bif.FetchAddr = 8'h12;
      bif.DataReq = 1'b1; bif.DataWe = 1'b0; bif.DataAddr = 8'hFF;
      n_ack = 0; last_ack = -1; order = '0;
      for (int c = 1; c <= 40 && n_ack < 4; c++) begin
         @(negedge Clk);
         if (bif.FetchAck) begin order[3 - n_ack] = 1'b0; n_ack++; last_ack = c; end
         else if (bif.DataAck) begin order[3 - n_ack] = 1'b1; n_ack++; last_ack = c; end
         if (n_ack == 4) begin bif.FetchReq = 1'b0; bif.DataReq = 1'b0; end
      end
      check("cont_ack_count", n_ack, 4);
      check("cont_order", order, 4'b0101);
      check("cont_last_ack_cycle", last_ack, 15);
      @(negedge Clk);

      // WAIT_CYCLES=3 instance, bus value tagged by cycle number
      bif3.FetchReq = 1'b1; bif3.FetchAddr = 8'h34; bus3_val = 16'h1000;
      ro_mask = '0; ack3 = -1; mar_c = -1; mar_bus = 'x;
      for (int c = 1; c <= 8; c++) begin
         @(negedge Clk);
         bus3_val = 16'h1000 + 16'(c);
         ro_mask[c] = bif3.RamOut;
         if (bif3.MarIn && mar_c < 0) begin mar_c = c; mar_bus = bif3.BusOut; end
         if (bif3.FetchAck && ack3 < 0) begin ack3 = c; bif3.FetchReq = 1'b0; end
      end
      check("w3_ramout_cycles", ro_mask, 9'b0_0001_1100);
      check("w3_ack_cycle", ack3, 5);
      check("w3_rddata", bif3.RdData, 16'h1004);
      check("w3_marin_cycle", mar_c, 1);
      check("w3_mar_busout", mar_bus, 16'h0034);

      // random requests, protocol-respecting; invariants monitored throughout
      fa = 0; da = 0; dw = 0; dwe = 0; fa_cnt = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge Clk);
         if (bif.FetchAck) begin
            check("rnd_fetch_rd", bif.RdData, mem[fa]);
            bif.FetchReq = 1'b0; fa_cnt++;
         end else if (!bif.FetchReq && $urandom_range(3) == 0) begin
            fa = 8'($urandom); bif.FetchAddr = fa; bif.FetchReq = 1'b1;
         end
         if (bif.DataAck) begin
            if (dwe) check("rnd_store_mem", mem[da], dw);
            else     check("rnd_load_rd", bif.RdData, mem[da]);
            bif.DataReq = 1'b0; fa_cnt++;
         end else if (!bif.DataReq && $urandom_range(3) == 0) begin
            da = 8'($urandom); dw = 16'($urandom); dwe = 1'($urandom);
            bif.DataAddr = da; bif.DataWData = dw; bif.DataWe = dwe; bif.DataReq = 1'b1;
         end
      end
      bif.FetchReq = 1'b0; bif.DataReq = 1'b0;
      check("rnd_progress", fa_cnt > 100, 1);
      repeat (8) @(negedge Clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
